// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the divider array scheduler.
// Holds the FSM state enum, the error quotient constant and the round-robin pick function.
package div_sched_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [31:0] ERR_RESP_Q = '1;
    localparam int          RR_MAX     = 8;

    // Returns {found, index}: first set bit of valid scanning ptr, ptr+1, ... modulo num.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                           input logic [2:0]        ptr,
                                           input int                num);
        logic       found;
        logic [2:0] idx;
        int         j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            j = int'(ptr) + i;
            if (j >= num) j = j - num;
            if ((i < num) && !found && valid[j[2:0]]) begin
                found = 1'b1;
                idx   = j[2:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/divider_array_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or after rr_ptr.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_valid
);

    logic [RR_MAX-1:0] v_pad;
    logic [3:0]        pick;

    always_comb begin
        v_pad                = '0;
        v_pad[NUM_REQ-1:0]   = req_valid;
        pick                 = rr_pick(v_pad, 3'(rr_ptr), NUM_REQ);
    end

    assign any_valid = pick[3];
    assign grant_idx = ID_W'(pick[2:0]);

    always_comb begin
        grant = '0;
        if (any_valid) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/divider_array_scheduler.sv
// Shares one external combinational array divider among NUM_REQ requesters.
// Screens divide-by-zero/overflow before issue and returns results on one response channel.
module divider_array_scheduler
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int N_W     = 16,
    parameter int D_W     = 8,
    parameter int LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*N_W-1:0]     req_n,
    input  logic [NUM_REQ*D_W-1:0]     req_d,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [N_W-1:0]             div_n,
    output logic [D_W-1:0]             div_d,
    input  logic [D_W-1:0]             div_q,
    input  logic [D_W-1:0]             div_r,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [D_W-1:0]             resp_q,
    output logic [D_W-1:0]             resp_r,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LAT + 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_valid;
    logic [N_W-1:0]    sel_n;
    logic [D_W-1:0]    sel_d;
    logic              accept;
    logic              err_now;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign sel_n     = req_n[grant_idx*N_W +: N_W];
    assign sel_d     = req_d[grant_idx*D_W +: D_W];
    // Quotient fits in D_W bits only when the upper dividend half is below the divisor.
    assign err_now   = (sel_d == '0) || (sel_n[N_W-1:D_W] >= sel_d);
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    accept    = 1'b1;
                    state_nxt = err_now ? RESP : CALC;
                end
            end
            CALC:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            div_n      <= '0;
            div_d      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        resp_id <= grant_idx;
                        if (err_now) begin
                            resp_q     <= ERR_RESP_Q[D_W-1:0];
                            resp_r     <= sel_n[D_W-1:0];
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                        end else begin
                            div_n <= sel_n;
                            div_d <= sel_d;
                            cnt   <= CNT_W'(LAT);
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        resp_q     <= div_q;
                        resp_r     <= div_r;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
